dm_ctrl: RTL



---
 rtl/dm_ctrl_if.sv | 27 ++
 rtl/dm_ctrl.sv | 137 +++++++++++++
 2 files changed

// File: rtl/dm_ctrl_if.sv
// Load/store request and response bundle between the MEM stage and the data memory controller.
interface dm_ctrl_if #(
    parameter int ADDR_W = 14,
    parameter int FCNT_W = 8
);
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              sign_ext;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       din;
    logic [31:0]       dout;
    logic              rvalid;
    logic              fault;
    logic [1:0]        fault_cause;
    logic [FCNT_W-1:0] fault_cnt;

    modport master (
        output req, we, size, sign_ext, addr, din,
        input  dout, rvalid, fault, fault_cause, fault_cnt
    );

    modport slave (
        input  req, we, size, sign_ext, addr, din,
        output dout, rvalid, fault, fault_cause, fault_cnt
    );
endinterface

// File: rtl/dm_ctrl.sv
// Byte-addressable data RAM with byte/half/word access, alignment and range checks,
// registered load port and a saturating fault counter. Storage is split into byte lanes.
module dm_lane #(
    parameter int ROWS  = 3072,
    parameter int ROW_W = 12,
    parameter int VEC_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  logic [VEC_W-1:0] wdata,
    output logic [VEC_W-1:0] rdata
);
    logic [VEC_W-1:0] mem [ROWS];

    always_ff @(posedge clk) begin
        if (we) mem[row] <= wdata;
    end

    assign rdata = mem[row];
endmodule

module dm_ctrl #(
    parameter int DEPTH  = 12288,
    parameter int ADDR_W = 14,
    parameter int FCNT_W = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    dm_ctrl_if.slave   bus
);
    localparam int NUM_LANES = 4;
    localparam int VEC_W     = 8;
    localparam int ROWS      = DEPTH / NUM_LANES;
    localparam int ROW_W     = ADDR_W - 2;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    localparam logic [1:0] C_NONE  = 2'b00;
    localparam logic [1:0] C_ALIGN = 2'b01;
    localparam logic [1:0] C_RANGE = 2'b10;
    localparam logic [1:0] C_SIZE  = 2'b11;

    logic [2:0]                            nbytes_m1;
    logic [NUM_LANES-1:0]                  be_base;
    logic [NUM_LANES-1:0]                  be;
    logic [ADDR_W:0]                       last;
    logic [1:0]                            cause;
    logic                                  bad;
    logic                                  wr_en;
    logic                                  rd_en;
    logic [NUM_LANES-1:0][VEC_W-1:0]       wdata;
    logic [NUM_LANES-1:0][VEC_W-1:0]       rdata;
    logic [31:0]                           rword;
    logic [31:0]                           shifted;
    logic [31:0]                           ld;

    // Decode size into lane mask and replicated store data; every legal access
    // stays inside one aligned word, so all lanes share the same row.
    always_comb begin
        nbytes_m1 = 3'd0;
        be_base   = 4'b0001;
        wdata     = {4{bus.din[7:0]}};
        case (bus.size)
            2'b01: begin
                nbytes_m1 = 3'd1;
                be_base   = 4'b0011;
                wdata     = {2{bus.din[15:0]}};
            end
            2'b10: begin
                nbytes_m1 = 3'd3;
                be_base   = 4'b1111;
                wdata     = bus.din;
            end
            default: ;
        endcase
        be = be_base << bus.addr[1:0];
    end

    // Range compare is done one bit wider than the address so it cannot wrap.
    always_comb begin
        last  = {1'b0, bus.addr} + {{(ADDR_W-2){1'b0}}, nbytes_m1};
        cause = C_NONE;
        if (bus.size == 2'b11)
            cause = C_SIZE;
        else if ((bus.size == 2'b01 && bus.addr[0]) ||
                 (bus.size == 2'b10 && bus.addr[1:0] != 2'b00))
            cause = C_ALIGN;
        else if (last >= DEPTH_L)
            cause = C_RANGE;
    end

    assign bad   = bus.req && (cause != C_NONE);
    assign wr_en = rst_n && bus.req && bus.we && (cause == C_NONE);
    assign rd_en = bus.req && !bus.we && (cause == C_NONE);

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        dm_lane #(
            .ROWS  (ROWS),
            .ROW_W (ROW_W),
            .VEC_W (VEC_W)
        ) u_lane (
            .clk   (clk),
            .we    (wr_en & be[i]),
            .row   (bus.addr[ADDR_W-1:2]),
            .wdata (wdata[i]),
            .rdata (rdata[i])
        );
    end

    assign rword   = rdata;
    assign shifted = rword >> {bus.addr[1:0], 3'b000};

    always_comb begin
        case (bus.size)
            2'b00:   ld = bus.sign_ext ? {{24{shifted[7]}},  shifted[7:0]}  : {24'b0, shifted[7:0]};
            2'b01:   ld = bus.sign_ext ? {{16{shifted[15]}}, shifted[15:0]} : {16'b0, shifted[15:0]};
            default: ld = rword;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bus.dout        <= 32'd0;
            bus.rvalid      <= 1'b0;
            bus.fault       <= 1'b0;
            bus.fault_cause <= C_NONE;
            bus.fault_cnt   <= '0;
        end else begin
            bus.rvalid <= rd_en;
            bus.fault  <= bad;
            if (rd_en) bus.dout <= ld;
            if (bus.req) bus.fault_cause <= cause;
            if (bad && bus.fault_cnt != {FCNT_W{1'b1}})
                bus.fault_cnt <= bus.fault_cnt + 1'b1;
        end
    end
endmodule
